memory_io: RTL and testbench

Memory and I/O slave sitting directly downstream of the CPU's memory port. It consumes `mem_cmd`, `mem_addr` and `write_data` and produces registered `read_data` one cycle after a read. It contains a synchronous-read RAM, a memory-mapped LED output register and a synchronized, debounced slide-switch input register. It also flags accesses to unmapped addresses.

---
 rtl/memory_io_if.sv | 11 +
 rtl/memory_io.sv | 111 +++++++++++
 tb/tb_memory_io.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/memory_io_if.sv
// CPU memory-port bundle between the CPU (master) and the memory/I-O slave.
// Carries the command, address, store data and registered load data.
interface memory_io_if;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] write_data;
    logic [15:0] read_data;

    modport master (output mem_cmd, output mem_addr, output write_data, input read_data);
    modport slave  (input mem_cmd, input mem_addr, input write_data, output read_data);
endinterface

// File: rtl/memory_io.sv
// Memory/I-O slave: sync-read RAM, LED output register, synchronized switch input, sticky bus error.
// Optional macro SW_DEBOUNCE_EN adds a whole-vector debounce counter on the switch path.
module memory_io #(
    parameter int RAM_WORDS       = 256,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    memory_io_if.slave  bus,
    input  logic [7:0]  SW,
    output logic [7:0]  LEDR,
    output logic        bus_err
);
    localparam int         AW        = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam logic [9:0] RAM_LIMIT = 10'(RAM_WORDS);
    localparam logic [8:0] LED_ADDR  = 9'h100;
    localparam logic [8:0] SW_ADDR   = 9'h140;
    localparam logic [1:0] CMD_WR    = 2'b00;
    localparam logic [1:0] CMD_RD    = 2'b01;

    generate
        if (RAM_WORDS < 1 || RAM_WORDS > 256) begin : g_bad_ram
            $error("memory_io: RAM_WORDS must be within 1..256");
        end
        if (DEBOUNCE_CYCLES < 2) begin : g_bad_deb
            $error("memory_io: DEBOUNCE_CYCLES must be at least 2");
        end
    endgenerate

    logic [15:0]   ram [RAM_WORDS];
    logic [15:0]   read_q;
    logic [AW-1:0] ram_idx;
    logic          is_rd, is_wr, ram_hit, led_hit, sw_hit, unmapped;
    logic [7:0]    s1, s2, sw_stable;

    always_comb begin
        is_rd    = (bus.mem_cmd == CMD_RD);
        is_wr    = (bus.mem_cmd == CMD_WR);
        ram_hit  = ({1'b0, bus.mem_addr} < RAM_LIMIT);
        led_hit  = (bus.mem_addr == LED_ADDR);
        sw_hit   = (bus.mem_addr == SW_ADDR);
        unmapped = (is_rd || is_wr) && !ram_hit && !led_hit && !sw_hit;
        ram_idx  = bus.mem_addr[AW-1:0];
    end

    // RAM array is deliberately not reset; writes during reset are dropped.
    always_ff @(posedge clk) begin
        if (reset && is_wr && ram_hit) begin
            ram[ram_idx] <= bus.write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            read_q  <= 16'h0000;
            LEDR    <= 8'h00;
            bus_err <= 1'b0;
        end else begin
            if (is_rd) begin
                if (ram_hit) begin
                    read_q <= ram[ram_idx];
                end else if (sw_hit) begin
                    read_q <= {8'h00, sw_stable};
                end else begin
                    read_q <= 16'h0000;
                end
            end
            if (is_wr && led_hit) begin
                LEDR <= bus.write_data[7:0];
            end
            if (unmapped) begin
                bus_err <= 1'b1;
            end
        end
    end

    assign bus.read_data = read_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1 <= 8'h00;
            s2 <= 8'h00;
        end else begin
            s1 <= SW;
            s2 <= s1;
        end
    end

`ifdef SW_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    logic [CW-1:0] cnt;

    // The count restarts only once s2 matches sw_stable again, not on every bit change.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sw_stable <= 8'h00;
            cnt       <= '0;
        end else if (s2 == sw_stable) begin
            cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            sw_stable <= s2;
            cnt       <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    assign sw_stable = s2;
`endif

endmodule

// File: tb/tb_memory_io.sv
// Self-checking bench for memory_io: directed literal checks plus randomized traffic
// compared every cycle against a behavioural model of the address map and switch path.
module tb_memory_io;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] SW = 8'h00;
    logic [7:0] LEDR;
    logic       bus_err;

    memory_io_if bus();

    memory_io #(.RAM_WORDS(256), .DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .reset(reset), .bus(bus), .SW(SW), .LEDR(LEDR), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] m_ram [256];
    bit          m_ram_ok [256];
    logic [15:0] m_rd;
    bit          m_rd_ok = 0;
    logic [7:0]  m_led;
    bit          m_err;
    logic [7:0]  m_s1, m_s2, m_stable;
    int          edge_n = 0;
    int          last_eq = 0;
    bit          m_live = 0;

    initial for (int i = 0; i < 256; i++) m_ram_ok[i] = 0;

    always @(posedge clk) begin
        if (!reset) begin
            m_rd = 16'h0; m_rd_ok = 1; m_led = 8'h0; m_err = 0;
            m_s1 = 8'h0; m_s2 = 8'h0; m_stable = 8'h0;
            last_eq = edge_n;
            m_live = 1;
        end else if (m_live) begin
            if (bus.mem_cmd == 2'b01) begin
                if (!bus.mem_addr[8]) begin
                    m_rd = m_ram[bus.mem_addr[7:0]];
                    m_rd_ok = m_ram_ok[bus.mem_addr[7:0]];
                end else if (bus.mem_addr == 9'h140) begin
                    m_rd = {8'h00, m_stable}; m_rd_ok = 1;
                end else begin
                    m_rd = 16'h0; m_rd_ok = 1;
                    if (bus.mem_addr != 9'h100) m_err = 1;
                end
            end else if (bus.mem_cmd == 2'b00) begin
                if (!bus.mem_addr[8]) begin
                    m_ram[bus.mem_addr[7:0]] = bus.write_data;
                    m_ram_ok[bus.mem_addr[7:0]] = 1;
                end else if (bus.mem_addr == 9'h100) begin
                    m_led = bus.write_data[7:0];
                end else if (bus.mem_addr != 9'h140) begin
                    m_err = 1;
                end
            end
`ifdef SW_DEBOUNCE_EN
            // stable follows s2 once s2 has differed from it for D edges in a row
            if (m_s2 == m_stable) last_eq = edge_n;
            else if (edge_n - last_eq >= D) begin
                m_stable = m_s2;
                last_eq = edge_n;
            end
            m_s2 = m_s1; m_s1 = SW;
`else
            m_s2 = m_s1; m_s1 = SW;
            m_stable = m_s2;
`endif
        end
        edge_n++;
    end

    always @(negedge clk) begin
        if (m_live) begin
            if (m_rd_ok) check("read_data_model", bus.read_data, m_rd);
            check("LEDR_model", {8'h00, LEDR}, {8'h00, m_led});
            check("bus_err_model", {15'h0, bus_err}, {15'h0, m_err});
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] data);
        bus.mem_cmd = cmd; bus.mem_addr = addr; bus.write_data = data;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(2'b10, 9'h0, 16'h0);
        reset = 1'b1;
    endtask

    int r;
    logic [8:0] ra;

    initial begin
        bus.mem_cmd = 2'b10; bus.mem_addr = 9'h0; bus.write_data = 16'h0;
        #2;
        // reset with a write to the LED register that must be discarded
        reset = 1'b0;
        bus.mem_cmd = 2'b00; bus.mem_addr = 9'h100; bus.write_data = 16'h00FF;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        bus.mem_cmd = 2'b10;
        check("rst_LEDR", {8'h00, LEDR}, 16'h0000);
        check("rst_read_data", bus.read_data, 16'h0000);
        check("rst_bus_err", {15'h0, bus_err}, 16'h0000);
        step(2'b10, 9'h0, 16'h0);
        check("post_rst_LEDR", {8'h00, LEDR}, 16'h0000);

        step(2'b00, 9'h005, 16'hBEEF);
        step(2'b01, 9'h005, 16'h0000);
        check("ram_rt", bus.read_data, 16'hBEEF);
        step(2'b10, 9'h005, 16'h0000);
        check("ram_hold", bus.read_data, 16'hBEEF);

        step(2'b00, 9'h100, 16'h1234);
        check("led_write", {8'h00, LEDR}, 16'h0034);
        check("led_rd_hold", bus.read_data, 16'hBEEF);
        step(2'b01, 9'h1FF, 16'h0000);
        check("unmapped_rd", bus.read_data, 16'h0000);
        check("unmapped_err", {15'h0, bus_err}, 16'h0001);
        for (int i = 0; i < 10; i++) begin
            step((i % 2) ? 2'b01 : 2'b00, 9'(i), 16'(i * 3 + 1));
            check("err_sticky", {15'h0, bus_err}, 16'h0001);
        end

        // switch path latency: read 0x140 every edge after SW changes
        do_reset();
        SW = 8'hA5;
        for (int k = 1; k <= 9; k++) begin
            step(2'b01, 9'h140, 16'h0);
`ifdef SW_DEBOUNCE_EN
            check("sw_latency", bus.read_data, (k >= D + 3) ? 16'h00A5 : 16'h0000);
`else
            check("sw_latency", bus.read_data, (k >= 3) ? 16'h00A5 : 16'h0000);
`endif
        end

        // short pulse
        SW = 8'h00;
        do_reset();
        repeat (3) step(2'b10, 9'h0, 16'h0);
        SW = 8'h01;
        repeat (3) step(2'b10, 9'h0, 16'h0);
        SW = 8'h00;
        for (int k = 0; k < 10; k++) begin
            step(2'b01, 9'h140, 16'h0);
`ifdef SW_DEBOUNCE_EN
            check("sw_pulse", bus.read_data, 16'h0000);
`endif
        end

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            reset = (r < 2) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 3) == 0) SW = 8'($urandom);
                else SW = SW ^ (8'h01 << $urandom_range(0, 7));
            end
            case ($urandom_range(0, 5))
                0, 1, 2: ra = 9'($urandom_range(0, 15));
                3:       ra = 9'h100;
                4:       ra = 9'h140;
                default: ra = 9'($urandom);
            endcase
            step(2'($urandom), ra, 16'($urandom));
        end
        reset = 1'b1;
        step(2'b10, 9'h0, 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
